// File: rtl/ddr3_user_cmdq_if.sv
// ddr3_user_cmdq_if: user push, PHY issue and read-return signals for the DDR3 user command queue
interface ddr3_user_cmdq_if;
  logic i_usr_cmd_en;
  logic i_usr_cmd_sel;
  logic [2:0] i3_usr_bank;
  logic [13:0] i14_usr_row;
  logic [9:0] i10_usr_col;
  logic [127:0] i128_usr_wrdata;
  logic o_usr_cmd_full;
  logic o_usr_ovf;
  logic o_usr_rddata_valid;
  logic [127:0] o128_usr_rddata;
  logic i_rdcal_done;
  logic i_phy_cmd_full;
  logic o_rdc_cmd_en;
  logic o_rdc_cmd_sel;
  logic [2:0] o3_rdc_bank;
  logic [13:0] o14_rdc_row;
  logic [9:0] o10_rdc_col;
  logic [127:0] o128_rdc_wrdata;
  logic i_phy_rddata_valid;
  logic [127:0] i128_phy_rddata;
  logic [3:0] o4_rd_outstanding;
  logic o_rd_err;
  modport slave (
    input i_usr_cmd_en, i_usr_cmd_sel, i3_usr_bank, i14_usr_row, i10_usr_col, i128_usr_wrdata,
    input i_rdcal_done, i_phy_cmd_full, i_phy_rddata_valid, i128_phy_rddata,
    output o_usr_cmd_full, o_usr_ovf, o_usr_rddata_valid, o128_usr_rddata,
    output o_rdc_cmd_en, o_rdc_cmd_sel, o3_rdc_bank, o14_rdc_row, o10_rdc_col, o128_rdc_wrdata,
    output o4_rd_outstanding, o_rd_err
  );
  modport master (
    output i_usr_cmd_en, i_usr_cmd_sel, i3_usr_bank, i14_usr_row, i10_usr_col, i128_usr_wrdata,
    output i_rdcal_done, i_phy_cmd_full, i_phy_rddata_valid, i128_phy_rddata,
    input o_usr_cmd_full, o_usr_ovf, o_usr_rddata_valid, o128_usr_rddata,
    input o_rdc_cmd_en, o_rdc_cmd_sel, o3_rdc_bank, o14_rdc_row, o10_rdc_col, o128_rdc_wrdata,
    input o4_rd_outstanding, o_rd_err
  );
endinterface

// File: rtl/ddr3_user_cmdq.sv
// ddr3_user_cmdq: in-order command FIFO issuing to the PHY with read-credit limiting and read-return forwarding
module ddr3_user_cmdq #(
  parameter int p_DEPTH = 8,
  parameter int p_MAX_RD = 8
) (
  input logic i_clk_div,
  input logic i_rst,
  ddr3_user_cmdq_if.slave bus
);
  localparam int AW = $clog2(p_DEPTH);
  localparam int W = 156;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state;
  logic [W-1:0] mem [p_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [W-1:0] head;
  logic full, push, pop, rd_inc, rd_acc;
  assign full = count == (AW+1)'(p_DEPTH);
  assign push = bus.i_usr_cmd_en && !full;
  assign head = mem[rd_ptr];
  // head[W-1] is the read select; writes never wait on read credits
  assign pop = state == IDLE && count != '0 && bus.i_rdcal_done && !bus.i_phy_cmd_full &&
               (!head[W-1] || bus.o4_rd_outstanding < 4'(p_MAX_RD));
  assign rd_inc = pop && head[W-1];
  assign rd_acc = bus.i_phy_rddata_valid && (bus.o4_rd_outstanding != '0 || rd_inc);
  assign bus.o_usr_cmd_full = full;
  always_ff @(posedge i_clk_div)
    if (push) mem[wr_ptr] <= {bus.i_usr_cmd_sel, bus.i3_usr_bank, bus.i14_usr_row, bus.i10_usr_col, bus.i128_usr_wrdata};
  always_ff @(posedge i_clk_div or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.o4_rd_outstanding <= '0;
      bus.o_usr_ovf <= 1'b0;
      bus.o_rd_err <= 1'b0;
      bus.o_usr_rddata_valid <= 1'b0;
      bus.o128_usr_rddata <= '0;
      bus.o_rdc_cmd_en <= 1'b0;
      {bus.o_rdc_cmd_sel, bus.o3_rdc_bank, bus.o14_rdc_row, bus.o10_rdc_col, bus.o128_rdc_wrdata} <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      bus.o4_rd_outstanding <= bus.o4_rd_outstanding + 4'(rd_inc) - 4'(rd_acc);
      if (bus.i_usr_cmd_en && full) bus.o_usr_ovf <= 1'b1;
      if (bus.i_phy_rddata_valid && !rd_acc) bus.o_rd_err <= 1'b1;
      bus.o_usr_rddata_valid <= rd_acc;
      if (rd_acc) bus.o128_usr_rddata <= bus.i128_phy_rddata;
      case (state)
        IDLE: if (pop) begin
          state <= ISSUE;
          bus.o_rdc_cmd_en <= 1'b1;
          {bus.o_rdc_cmd_sel, bus.o3_rdc_bank, bus.o14_rdc_row, bus.o10_rdc_col, bus.o128_rdc_wrdata} <= head;
        end
        ISSUE: begin
          state <= GAP;
          bus.o_rdc_cmd_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr3_user_cmdq.sv
// tb_ddr3_user_cmdq: directed and random stimulus checked against a queue/credit reference model
module tb_ddr3_user_cmdq;
  localparam int DEPTH = 8;
  localparam int MAX_RD = 8;
  typedef struct packed {
    logic sel;
    logic [2:0] bank;
    logic [13:0] row;
    logic [9:0] col;
    logic [127:0] data;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ddr3_user_cmdq_if ifc();
  ddr3_user_cmdq #(.p_DEPTH(DEPTH), .p_MAX_RD(MAX_RD)) dut (.i_clk_div(clk), .i_rst(rst), .bus(ifc.slave));
  cmd_t q[$];
  int itimes[$];
  int total = 0, bad = 0, n_issue = 0, model_out = 0, cyc = 0, last_issue = -100;
  logic err_m = 1'b0, ovf_m = 1'b0;
  logic [127:0] rd_m = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) begin : mon
    cmd_t got, e;
    logic rd_iss, acc;
    if (!rst) begin
      rd_iss = 1'b0;
      if (ifc.o_rdc_cmd_en) begin
        got = cmd_t'({ifc.o_rdc_cmd_sel, ifc.o3_rdc_bank, ifc.o14_rdc_row, ifc.o10_rdc_col, ifc.o128_rdc_wrdata});
        n_issue++;
        itimes.push_back(cyc);
        chk("issue_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("issue_order", got, e);
        end
        chk("issue_rdcal", ifc.i_rdcal_done, 1);
        chk("issue_phyfull", ifc.i_phy_cmd_full, 0);
        chk("issue_spacing", cyc - last_issue >= 3, 1);
        last_issue = cyc;
        if (got.sel) begin
          chk("max_rd", model_out < MAX_RD, 1);
          rd_iss = 1'b1;
        end
      end
      acc = ifc.i_phy_rddata_valid && (model_out > 0 || rd_iss);
      if (ifc.i_phy_rddata_valid && !acc) err_m = 1'b1;
      if (acc) rd_m = ifc.i128_phy_rddata;
      model_out = model_out + int'(rd_iss) - int'(acc);
      chk("outstanding", ifc.o4_rd_outstanding, model_out);
      chk("usr_valid", ifc.o_usr_rddata_valid, acc);
      chk("usr_data", ifc.o128_usr_rddata, rd_m);
      chk("rd_err", ifc.o_rd_err, err_m);
      chk("ovf", ifc.o_usr_ovf, ovf_m);
      chk("full", ifc.o_usr_cmd_full, q.size() == DEPTH);
    end
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic drive_push(logic sel, logic [2:0] b, logic [13:0] r, logic [9:0] c, logic [127:0] d);
    ifc.i_usr_cmd_en = 1'b1;
    ifc.i_usr_cmd_sel = sel;
    ifc.i3_usr_bank = b;
    ifc.i14_usr_row = r;
    ifc.i10_usr_col = c;
    ifc.i128_usr_wrdata = d;
    if (q.size() < DEPTH) q.push_back(cmd_t'({sel, b, r, c, d}));
    else ovf_m = 1'b1;
  endtask
  task automatic push(logic sel, logic [2:0] b, logic [13:0] r, logic [9:0] c, logic [127:0] d);
    drive_push(sel, b, r, c, d);
    step();
    ifc.i_usr_cmd_en = 1'b0;
  endtask
  task automatic push_rnd(logic sel);
    push(sel, 3'($urandom), 14'($urandom), 10'($urandom), rnd128());
  endtask
  task automatic ret();
    ifc.i_phy_rddata_valid = 1'b1;
    ifc.i128_phy_rddata = rnd128();
    step();
    ifc.i_phy_rddata_valid = 1'b0;
  endtask
  task automatic drain();
    int k = 0;
    ifc.i_rdcal_done = 1'b1;
    ifc.i_phy_cmd_full = 1'b0;
    while ((q.size() > 0 || model_out > 0) && k < 400) begin
      if (model_out > 0 && $urandom_range(0, 1) == 1) ret();
      else step();
      k++;
    end
    chk("drain_bound", k < 400, 1);
    step(3);
  endtask
  task automatic chk_all_zero(string tag);
    chk({tag, "_cmd_en"}, ifc.o_rdc_cmd_en, 0);
    chk({tag, "_fields"}, {ifc.o_rdc_cmd_sel, ifc.o3_rdc_bank, ifc.o14_rdc_row, ifc.o10_rdc_col}, 0);
    chk({tag, "_wrdata"}, ifc.o128_rdc_wrdata, 0);
    chk({tag, "_full"}, ifc.o_usr_cmd_full, 0);
    chk({tag, "_ovf"}, ifc.o_usr_ovf, 0);
    chk({tag, "_rdv"}, ifc.o_usr_rddata_valid, 0);
    chk({tag, "_rddata"}, ifc.o128_usr_rddata, 0);
    chk({tag, "_outst"}, ifc.o4_rd_outstanding, 0);
    chk({tag, "_rderr"}, ifc.o_rd_err, 0);
  endtask
  initial begin
    int n0, sz;
    ifc.i_usr_cmd_en = 1'b0;
    ifc.i_usr_cmd_sel = 1'b0;
    ifc.i3_usr_bank = '0;
    ifc.i14_usr_row = '0;
    ifc.i10_usr_col = '0;
    ifc.i128_usr_wrdata = '0;
    ifc.i_rdcal_done = 1'b0;
    ifc.i_phy_cmd_full = 1'b0;
    ifc.i_phy_rddata_valid = 1'b0;
    ifc.i128_phy_rddata = '0;
    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    ifc.i_rdcal_done = 1'b1;
    step(2);
    // single write: issue one cycle after the push is visible, fields held afterwards
    push(1'b0, 3'd1, 14'd5, 10'd8, {16{8'hA5}});
    chk("lat_early", ifc.o_rdc_cmd_en, 0);
    step();
    chk("lat_issue", ifc.o_rdc_cmd_en, 1);
    chk("wr_sel", ifc.o_rdc_cmd_sel, 0);
    chk("wr_data", ifc.o128_rdc_wrdata, {16{8'hA5}});
    step();
    chk("one_cycle", ifc.o_rdc_cmd_en, 0);
    chk("hold_bank", ifc.o3_rdc_bank, 1);
    chk("hold_row", ifc.o14_rdc_row, 5);
    chk("wr_outst", ifc.o4_rd_outstanding, 0);
    step(3);
    // fill to full with calibration pending, then one overflowing push
    ifc.i_rdcal_done = 1'b0;
    n0 = n_issue;
    for (int i = 0; i < 9; i++) begin
      push_rnd(1'b0);
      if (i == 7) begin
        chk("full_after8", ifc.o_usr_cmd_full, 1);
        chk("no_ovf_at8", ifc.o_usr_ovf, 0);
      end
    end
    chk("ovf_after9", ifc.o_usr_ovf, 1);
    step(5);
    chk("no_issue_uncal", n_issue - n0, 0);
    drain();
    chk("drain8", n_issue - n0, 8);
    // read credit limit
    n0 = n_issue;
    for (int i = 0; i < 10; i++) push_rnd(1'b1);
    step(40);
    chk("rd_limit_issues", n_issue - n0, 8);
    chk("rd_limit_outst", ifc.o4_rd_outstanding, 8);
    ret();
    step(5);
    chk("rd_ninth", n_issue - n0, 9);
    drain();
    chk("rd_all", n_issue - n0, 10);
    // stray return with nothing outstanding
    ret();
    chk("rd_err_set", ifc.o_rd_err, 1);
    chk("stray_no_fwd", ifc.o_usr_rddata_valid, 0);
    step(3);
    chk("rd_err_sticky", ifc.o_rd_err, 1);
    // PHY backpressure then release: issues exactly 3 cycles apart
    ifc.i_phy_cmd_full = 1'b1;
    n0 = n_issue;
    push_rnd(1'b0);
    push_rnd(1'b1);
    push_rnd(1'b0);
    step(10);
    chk("phyfull_block", n_issue - n0, 0);
    ifc.i_phy_cmd_full = 1'b0;
    step(12);
    chk("phyfull_release", n_issue - n0, 3);
    sz = itimes.size();
    chk("gap_a", itimes[sz-1] - itimes[sz-2], 3);
    chk("gap_b", itimes[sz-2] - itimes[sz-3], 3);
    drain();
    for (int i = 0; i < 400; i++) begin
      ifc.i_rdcal_done = $urandom_range(0, 7) != 0;
      ifc.i_phy_cmd_full = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 1) == 1) drive_push(1'($urandom), 3'($urandom), 14'($urandom), 10'($urandom), rnd128());
      else ifc.i_usr_cmd_en = 1'b0;
      ifc.i_phy_rddata_valid = $urandom_range(0, 3) == 0;
      ifc.i128_phy_rddata = rnd128();
      step();
    end
    ifc.i_usr_cmd_en = 1'b0;
    ifc.i_phy_rddata_valid = 1'b0;
    drain();
    // asynchronous reset with queued commands and outstanding reads
    push_rnd(1'b1);
    push_rnd(1'b1);
    step(8);
    chk("pre_rst_outst", ifc.o4_rd_outstanding, 2);
    ifc.i_phy_cmd_full = 1'b1;
    for (int i = 0; i < 4; i++) push_rnd(1'b0);
    step(2);
    #2;
    rst = 1'b1;
    q.delete();
    model_out = 0;
    err_m = 1'b0;
    ovf_m = 1'b0;
    rd_m = '0;
    last_issue = -100;
    #1;
    chk_all_zero("async_rst");
    step(2);
    rst = 1'b0;
    ifc.i_phy_cmd_full = 1'b0;
    n0 = n_issue;
    step(10);
    chk("post_rst_idle", n_issue - n0, 0);
    push_rnd(1'b0);
    step(4);
    chk("post_rst_push", n_issue - n0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
